// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: writable instruction store, NOP-cleared after reset, 1-cycle fetch, loader write port
module instruction_memory_loadable #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  initDone,
  input  logic                  fetchValid,
  input  logic [ADDR_WIDTH-1:0] fetchAddress,
  output logic                  fetchReady,
  output logic                  instructionValid,
  output logic [31:0]           instruction,
  output logic                  fetchFault,
  input  logic                  loadValid,
  input  logic [ADDR_WIDTH-1:0] loadAddress,
  input  logic [31:0]           loadData,
  output logic                  loadReady,
  output logic                  loadFault
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t          r_state;
  logic [IW-1:0]   r_clear_idx;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic            r_ivalid;
  logic [31:0]     r_instr;
  logic            r_ffault;
  logic            r_lfault;
  logic [IW:0]     w_fdec;
  logic [IW:0]     w_ldec;
  logic            w_ready;
  logic            w_fetch_acc;
  logic            w_load_acc;
  // {fault, word index}; high bits beyond the array must be zero so nothing aliases
  function automatic logic [IW:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return {(a < BASE_ADDR) || (a[1:0] != 2'b00) || ((off >> (IW + 2)) != '0), off[IW+1:2]};
  endfunction
  assign w_fdec = decode(fetchAddress);
  assign w_ldec = decode(loadAddress);
  assign w_ready = r_state == S_READY;
  assign w_fetch_acc = fetchValid && w_ready;
  assign w_load_acc = loadValid && w_ready;
  assign initDone = w_ready;
  assign fetchReady = w_ready;
  assign loadReady = w_ready;
  assign instructionValid = r_ivalid;
  assign instruction = r_instr;
  assign fetchFault = r_ffault;
  assign loadFault = r_lfault;
  always_ff @(posedge clk)
    if (!reset)
      if (r_state == S_CLEAR) r_mem[r_clear_idx] <= NOP_WORD;
      else if (w_load_acc && !w_ldec[IW]) r_mem[w_ldec[IW-1:0]] <= loadData;
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_CLEAR;
      r_clear_idx <= '0;
      r_ivalid <= 1'b0;
      r_instr <= NOP_WORD;
      r_ffault <= 1'b0;
      r_lfault <= 1'b0;
    end else begin
      r_ivalid <= w_fetch_acc;
      r_ffault <= w_fetch_acc && w_fdec[IW];
      r_lfault <= w_load_acc && w_ldec[IW];
      if (w_fetch_acc) r_instr <= w_fdec[IW] ? NOP_WORD : r_mem[w_fdec[IW-1:0]];
      if (r_state == S_CLEAR) begin
        r_clear_idx <= r_clear_idx + IW'(1);
        if (r_clear_idx == IW'(DEPTH_WORDS - 1)) r_state <= S_READY;
      end
    end
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb_instruction_memory_loadable: scoreboard bench for the default build and a 16-word, 0x1000-based variant
module tb_instruction_memory_loadable;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, fetchValid = 1'b0, loadValid = 1'b0;
  logic [63:0] fetchAddress = '0, loadAddress = '0;
  logic [31:0] loadData = '0;
  logic initDone, fetchReady, instructionValid, fetchFault, loadReady, loadFault;
  logic [31:0] instruction;
  logic v_reset = 1'b1, v_fetchValid = 1'b0, v_loadValid = 1'b0;
  logic [63:0] v_fetchAddress = '0, v_loadAddress = '0;
  logic [31:0] v_loadData = '0;
  logic v_initDone, v_fetchReady, v_instructionValid, v_fetchFault, v_loadReady, v_loadFault;
  logic [31:0] v_instruction;
  int errors = 0, checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] v_q[$];
  logic exp_lf = 1'b0;
  instruction_memory_loadable dut (
    .clk(clk), .reset(reset), .initDone(initDone),
    .fetchValid(fetchValid), .fetchAddress(fetchAddress), .fetchReady(fetchReady),
    .instructionValid(instructionValid), .instruction(instruction), .fetchFault(fetchFault),
    .loadValid(loadValid), .loadAddress(loadAddress), .loadData(loadData),
    .loadReady(loadReady), .loadFault(loadFault));
  instruction_memory_loadable #(.DEPTH_WORDS(16), .BASE_ADDR(64'h1000)) dut_v (
    .clk(clk), .reset(v_reset), .initDone(v_initDone),
    .fetchValid(v_fetchValid), .fetchAddress(v_fetchAddress), .fetchReady(v_fetchReady),
    .instructionValid(v_instructionValid), .instruction(v_instruction), .fetchFault(v_fetchFault),
    .loadValid(v_loadValid), .loadAddress(v_loadAddress), .loadData(v_loadData),
    .loadReady(v_loadReady), .loadFault(v_loadFault));
  task automatic cyc();
    logic [32:0] e;
    @(posedge clk); #1;
    if (instructionValid || exp_q.size() != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL fetch_spurious got valid=%0b expected 0", instructionValid);
      end else begin
        e = exp_q.pop_front();
        if ({instructionValid, fetchFault, instruction} !== {1'b1, e}) begin
          errors++;
          $display("FAIL fetch_result got v=%0b f=%0b d=%h expected v=1 f=%0b d=%h",
                   instructionValid, fetchFault, instruction, e[32], e[31:0]);
        end
      end
    end
    if (loadFault || exp_lf) begin
      checks++;
      if (loadFault !== exp_lf) begin
        errors++; $display("FAIL load_fault got %0b expected %0b", loadFault, exp_lf);
      end
    end
    exp_lf = 1'b0;
  endtask
  task automatic fetch(input logic [63:0] a, input logic [31:0] d, input logic f);
    fetchValid = 1'b1; fetchAddress = a; exp_q.push_back({f, d});
  endtask
  task automatic load(input logic [63:0] a, input logic [31:0] d, input logic f);
    loadValid = 1'b1; loadAddress = a; loadData = d; exp_lf = f;
  endtask
  task automatic idle();
    fetchValid = 1'b0; loadValid = 1'b0;
  endtask
  task automatic wait_init(input string name);
    int n = 0, bad = 0;
    while (!initDone && n < 3000) begin
      @(posedge clk); #1; n++;
      if (instructionValid) bad++;
    end
    fetchValid = 1'b0;
    checks++;
    if (n !== 1024) begin errors++; $display("FAIL %s_init_cycles got %0d expected 1024", name, n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_clear_accepts got %0d valid cycles expected 0", name, bad); end
  endtask
  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({initDone, fetchReady, loadReady, instructionValid, fetchFault, loadFault, instruction} !== {6'b0, NOP}) begin
      errors++;
      $display("FAIL reset_state got %b_%h expected 000000_%h",
               {initDone, fetchReady, loadReady, instructionValid, fetchFault, loadFault}, instruction, NOP);
    end
    reset = 1'b0;
    wait_init("reset");
  endtask
  task automatic test_init_fetch();
    fetch(64'h0, NOP, 1'b0); cyc();
    fetch(64'hFFC, NOP, 1'b0); cyc();
    idle();
  endtask
  task automatic test_back_to_back();
    int n = 0;
    load(64'h8, 32'h00500093, 1'b0); cyc();
    load(64'hC, 32'h00108113, 1'b0); cyc();
    idle();
    fetch(64'h8, 32'h00500093, 1'b0); cyc(); n += int'(instructionValid);
    fetch(64'hC, 32'h00108113, 1'b0); cyc(); n += int'(instructionValid);
    fetch(64'h8, 32'h00500093, 1'b0); cyc(); n += int'(instructionValid);
    idle();
    checks++;
    if (n !== 3) begin errors++; $display("FAIL b2b_valid_run got %0d expected 3", n); end
    cyc();
    checks++;
    if ({instructionValid, fetchFault, instruction} !== {2'b00, 32'h00500093}) begin
      errors++;
      $display("FAIL hold got v=%0b f=%0b d=%h expected v=0 f=0 d=00500093", instructionValid, fetchFault, instruction);
    end
  endtask
  task automatic test_faults();
    load(64'h0, 32'hCAFE0001, 1'b0); cyc(); idle();
    fetch(64'h6, NOP, 1'b1); cyc();
    fetch(64'h1000, NOP, 1'b1); cyc();
    fetch(64'hFFFF_FFFF_FFFF_FFFC, NOP, 1'b1); cyc();
    idle();
    load(64'h1000, 32'h99999999, 1'b1); cyc();
    load(64'h2, 32'h77777777, 1'b1); cyc();
    idle(); cyc();
    fetch(64'h0, 32'hCAFE0001, 1'b0); cyc();
    idle();
  endtask
  task automatic test_same_cycle();
    load(64'h10, 32'hAAAAAAAA, 1'b0); cyc(); idle();
    load(64'h10, 32'hBBBBBBBB, 1'b0); fetch(64'h10, 32'hAAAAAAAA, 1'b0); cyc(); idle();
    fetch(64'h10, 32'hBBBBBBBB, 1'b0); cyc(); idle();
  endtask
  task automatic test_reset_mid();
    load(64'h0, 32'h12345678, 1'b0); cyc(); idle();
    fetch(64'h0, 32'h12345678, 1'b0); cyc(); idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({fetchReady, initDone} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_ready got %b expected 00", {fetchReady, initDone});
    end
    fetchValid = 1'b1; fetchAddress = 64'h0;
    wait_init("mid");
    fetch(64'h0, NOP, 1'b0); cyc(); idle();
  endtask
  task automatic test_variant();
    logic [63:0] addrs[4] = '{64'hFFC, 64'h1000, 64'h103C, 64'h1040};
    logic [32:0] exps[4] = '{{1'b1, NOP}, {1'b0, NOP}, {1'b0, 32'h0BADF00D}, {1'b1, NOP}};
    logic [32:0] e;
    int n = 0;
    v_reset = 1'b0;
    while (!v_initDone && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL var_init_cycles got %0d expected 16", n); end
    v_loadValid = 1'b1; v_loadAddress = 64'h103C; v_loadData = 32'h0BADF00D;
    @(posedge clk); #1;
    v_loadValid = 1'b0;
    checks++;
    if (v_loadFault !== 1'b0) begin errors++; $display("FAIL var_load_fault got %0b expected 0", v_loadFault); end
    for (int i = 0; i < 4; i++) begin
      v_fetchValid = 1'b1; v_fetchAddress = addrs[i]; v_q.push_back(exps[i]);
      @(posedge clk); #1;
      v_fetchValid = 1'b0;
      e = v_q.pop_front();
      checks++;
      if ({v_instructionValid, v_fetchFault, v_instruction} !== {1'b1, e}) begin
        errors++;
        $display("FAIL var_fetch_%h got v=%0b f=%0b d=%h expected v=1 f=%0b d=%h",
                 addrs[i], v_instructionValid, v_fetchFault, v_instruction, e[32], e[31:0]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_init_fetch();
    test_back_to_back();
    test_faults();
    test_same_cycle();
    test_reset_mid();
    test_variant();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_memory_loadable.md
Name: instruction_memory_loadable

Overview:
- Parametrised, synchronous, writable instruction memory; successor to the hard-coded instruction store.
- Sits between the instruction-fetch stage and the boot loader.
- After reset it self-initialises every word to NOP, then serves fetches with 1-cycle latency and accepts word writes from a loader port, for example when copying code in from an SD card.
- Flags misaligned and out-of-range accesses instead of aliasing them.

Parameters:
- ADDR_WIDTH, 64, width of the fetch and load byte addresses.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two and at least 2.
- BASE_ADDR, 0, byte address of word 0; must be 4-byte aligned.
- NOP_WORD, 32'h00000013, fill value written during init and returned on a fault.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- initDone  out  1  high once the init clear has finished.
- fetchValid  in  1  fetch request.
- fetchAddress  in  ADDR_WIDTH  fetch byte address.
- fetchReady  out  1  fetch can be accepted this cycle.
- instructionValid  out  1  one-cycle pulse: instruction and fetchFault are valid.
- instruction  out  32  fetched word.
- fetchFault  out  1  the accepted fetch was misaligned or out of range.
- loadValid  in  1  write request.
- loadAddress  in  ADDR_WIDTH  write byte address.
- loadData  in  32  write data.
- loadReady  out  1  write can be accepted this cycle.
- loadFault  out  1  one-cycle pulse: the accepted write was misaligned or out of range and was dropped.

Behaviour:
- Reset values: initDone=0, fetchReady=0, loadReady=0, instructionValid=0, instruction=NOP_WORD, fetchFault=0, loadFault=0. Memory contents are not reset directly; the CLEAR state overwrites them.
- State machine CLEAR -> READY.
  - reset (at any time, including mid-CLEAR or mid-READY) forces CLEAR with clearIndex=0.
  - CLEAR writes NOP_WORD to mem[clearIndex] and increments clearIndex each cycle.
  - After writing index DEPTH_WORDS-1, go to READY. CLEAR lasts exactly DEPTH_WORDS cycles.
  - In READY: initDone=1, fetchReady=1, loadReady=1. All three are 0 in CLEAR.
- Address decode (fetch and load identical):
  - offset = addr - BASE_ADDR, computed ADDR_WIDTH wide.
  - Fault if addr < BASE_ADDR, or addr[1:0] != 0, or offset[ADDR_WIDTH-1:2] >= DEPTH_WORDS.
  - Otherwise index = offset[log2(DEPTH_WORDS)+1:2].
  - No aliasing of high address bits.
- Fetch: accepted when fetchValid && fetchReady at edge N.
  - At edge N+1 (visible the cycle after acceptance): instructionValid=1, and either instruction=mem[index], fetchFault=0, or instruction=NOP_WORD, fetchFault=1.
  - Fetches are pipelined: back-to-back requests give back-to-back results.
  - With no accepted fetch: instructionValid=0, fetchFault=0, instruction holds its last value.
- Load: accepted when loadValid && loadReady at edge N.
  - A valid address writes mem[index]=loadData at edge N.
  - A faulting address writes nothing and gives loadFault=1 in the following cycle.
- Simultaneous fetch and load to the same word: read-first. The fetch returns the pre-write contents and the new data is visible to the next fetch.
- Requests presented during CLEAR are not accepted and are not queued.
- No backpressure on the output: the consumer must take a result in its valid cycle.

Test Plan:
- Reset then idle: initDone rises exactly 1024 cycles after reset deasserts. A fetch at addr 0x0 and at 0xFFC each return 32'h00000013 with fetchFault=0, one cycle after acceptance.
- Load 0x00500093 at 0x8 and 0x00108113 at 0xC, then back-to-back fetches 0x8, 0xC, 0x8 -> instructionValid high for three consecutive cycles with 0x00500093, 0x00108113, 0x00500093.
- Faults: fetch at 0x6 -> NOP_WORD with fetchFault=1. Fetch at 0x1000 (DEPTH 1024) -> fetchFault=1, no alias to word 0. Load at 0x1000 -> loadFault pulse and word 0 unchanged.
- Same cycle: mem[4]=0xAAAAAAAA, then load 0xBBBBBBBB at 0x10 together with a fetch at 0x10 -> returns 0xAAAAAAAA. The next fetch at 0x10 returns 0xBBBBBBBB.
- Reset mid-operation: after loading 0x12345678 at 0x0, assert reset for 1 cycle in READY. fetchReady drops the next cycle, initDone returns after 1024 cycles, and a fetch at 0x0 returns 32'h00000013.
- Parameter variant DEPTH_WORDS=16, BASE_ADDR=0x1000: fetch at 0xFFC faults, 0x1000 and 0x103C succeed, 0x1040 faults. initDone rises after 16 cycles.
